// File: rtl/sdm_modulator.sv
// sdm_modulator: PCM-to-bitstream sigma-delta modulator.
//
// Each accepted signed PCM sample is held for OSR bit-clock cycles. A noise-shaping loop emits
// one bit per cycle. The first bit appears in the cycle after acceptance. When the source does
// not supply a new sample at the end of a period, the old sample repeats and underrun pulses.
//
// Build option: define SDM_ORDER2_EN for a second-order CIFB loop with the input clamped to
// +/-(3/4)FS. When it is undefined, the block uses a first-order loop with no clamp.
//
// Ports:
//   clk        bit clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   valid_in   PCM sample valid
//   ready_in   block accepts a sample this cycle
//   din        signed PCM sample (DATA_W bits)
//   valid_out  dout carries a modulator bit
//   dout       bitstream, 1 = +FS, 0 = -FS
//   underrun   one-cycle pulse after a period ended with no new sample
module sdm_modulator #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OSR    = 64,
    parameter int unsigned ACC_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    output logic                     ready_in,
    input  logic signed [DATA_W-1:0] din,
    output logic                     valid_out,
    output logic                     dout,
    output logic                     underrun
);

    localparam int unsigned CNT_W = (OSR > 2) ? $clog2(OSR) : 1;
    // Two guard bits keep the unsaturated loop sums free of overflow.
    localparam int unsigned SUM_W = ACC_W + 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
    localparam logic signed [SUM_W-1:0] FS_VAL =
        {{(SUM_W - DATA_W){1'b0}}, 1'b1, {(DATA_W - 1){1'b0}}};
    localparam logic signed [SUM_W-1:0] ACC_MAX = {3'b000, {(ACC_W - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN = {3'b111, {(ACC_W - 1){1'b0}}};

    typedef enum logic [0:0] {StIdle, StRun} state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [DATA_W-1:0]   sample_q, sample_d;
    logic signed [ACC_W-1:0]    i1_q, i1_d, i1_next;
    logic                       dout_q, dout_d, bit_next;
    logic                       underrun_q, underrun_d;
    logic signed [SUM_W-1:0]    fb, x_raw, x, sum1;

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [SUM_W-1:0] v);
        if (v > ACC_MAX) begin
            return ACC_MAX[ACC_W-1:0];
        end else if (v < ACC_MIN) begin
            return ACC_MIN[ACC_W-1:0];
        end
        return v[ACC_W-1:0];
    endfunction

    assign fb    = dout_q ? FS_VAL : -FS_VAL;
    assign x_raw = {{(SUM_W - DATA_W){sample_q[DATA_W-1]}}, sample_q};
    assign sum1  = {{2{i1_q[ACC_W-1]}}, i1_q} + x - fb;
    assign i1_next = sat(sum1);

`ifdef SDM_ORDER2_EN
    localparam logic signed [SUM_W-1:0] CLAMP_HI = FS_VAL - (FS_VAL >>> 2);
    localparam logic signed [SUM_W-1:0] CLAMP_LO = -CLAMP_HI;

    logic signed [ACC_W-1:0] i2_q, i2_d, i2_next;
    logic signed [SUM_W-1:0] sum2;

    // Second-order loop is only stable for inputs within +/-(3/4)FS.
    assign x = (x_raw > CLAMP_HI) ? CLAMP_HI : ((x_raw < CLAMP_LO) ? CLAMP_LO : x_raw);
    assign sum2 = {{2{i2_q[ACC_W-1]}}, i2_q} + {{2{i1_next[ACC_W-1]}}, i1_next} - fb;
    assign i2_next  = sat(sum2);
    assign bit_next = ~i2_next[ACC_W-1];

    always_comb begin
        i2_d = i2_q;
        if (state_q == StRun) begin
            i2_d = i2_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i2_q <= '0;
        end else begin
            i2_q <= i2_d;
        end
    end
`else
    assign x        = x_raw;
    assign bit_next = ~i1_next[ACC_W-1];
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sample_d   = sample_q;
        i1_d       = i1_q;
        dout_d     = dout_q;
        underrun_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (valid_in) begin
                    sample_d = din;
                    cnt_d    = CNT_LAST;
                    state_d  = StRun;
                end
            end
            StRun: begin
                i1_d   = i1_next;
                dout_d = bit_next;
                if (cnt_q == '0) begin
                    cnt_d = CNT_LAST;
                    if (valid_in) begin
                        sample_d = din;
                    end else begin
                        // Source missed its slot: repeat the held sample.
                        underrun_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sample_q   <= '0;
            i1_q       <= '0;
            dout_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sample_q   <= sample_d;
            i1_q       <= i1_d;
            dout_q     <= dout_d;
            underrun_q <= underrun_d;
        end
    end

    assign ready_in  = (state_q == StIdle) || (cnt_q == '0);
    assign valid_out = (state_q == StRun);
    assign dout      = (state_q == StRun) && dout_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_sdm_modulator.sv
// Self-checking bench for sdm_modulator (default parameters). Expected ones-per-window values
// are pushed to a scoreboard when a sample is accepted or repeated, and are popped when the DUT
// completes each 64-bit window.
module tb_sdm_modulator;

    localparam int OSR = 64;
`ifdef SDM_ORDER2_EN
    localparam int TOL = 2;
    localparam bit ORDER1 = 1'b0;
`else
    localparam int TOL = 1;
    localparam bit ORDER1 = 1'b1;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               valid_in;
    logic               ready_in;
    logic signed [15:0] din;
    logic               valid_out;
    logic               dout;
    logic               underrun;

    sdm_modulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .din       (din),
        .valid_out (valid_out),
        .dout      (dout),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ones;
        int tol;
        bit chk;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   gaps    = 0;
    int   got_ur  = 0;
    int   exp_ur  = 0;
    int   last_s  = 0;

    task automatic check(input string tag, input int got, input int exp, input int tol);
        n_tests++;
        if (got < exp - tol || got > exp + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (+/-%0d) at %0t", tag, got, exp, tol,
                     $time);
        end
    endtask

    function automatic int exp_ones(input int s);
        int xv = s;
`ifdef SDM_ORDER2_EN
        if (xv > 24576) xv = 24576;
        if (xv < -24576) xv = -24576;
`endif
        return (xv + 32768 + 512) / 1024;
    endfunction

    task automatic push(input int s);
        exp_t e;
        e.ones = exp_ones(s);
        e.tol  = TOL;
        e.chk  = ORDER1 || (s == last_s);
        last_s = s;
        sb_q.push_back(e);
    endtask

    // Monitor: samples at the falling edge, halfway between active edges.
    initial begin
        int   ones = 0, bits = 0, rdy_win = 0, settle = 2, cyc = 0, last_ur = -1;
        bit   started = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                ones = 0; bits = 0; rdy_win = 0; settle = 2; started = 1'b0; last_ur = -1;
            end else begin
                cyc++;
                if (valid_out) begin
                    started = 1'b1;
                    ones += int'(dout);
                    bits++;
                    if (ready_in) rdy_win++;
                    if (bits == OSR) begin
                        if (sb_q.size() == 0) begin
                            check("scoreboard_empty", 0, 1, 0);
                        end else begin
                            e = sb_q.pop_front();
                            if (settle > 0) settle--;
                            else if (e.chk) check("window_ones", ones, e.ones, e.tol);
                        end
                        check("ready_per_window", rdy_win, 1, 0);
                        ones = 0; bits = 0; rdy_win = 0;
                    end
                end else if (started) begin
                    gaps++;
                end
                if (underrun) begin
                    got_ur++;
                    if (last_ur >= 0) check("underrun_period", cyc - last_ur, OSR, 0);
                    last_ur = cyc;
                end
                if (ready_in && valid_in) begin
                    push(int'(din));
                end else if (ready_in && valid_out) begin
                    push(last_s);
                    exp_ur++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Presents a sample and returns just after the edge that accepts it.
    task automatic feed(input int s);
        int n = 0;
        din      = 16'(s);
        valid_in = 1'b1;
        @(negedge clk);
        while (!ready_in && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_in) check("feed_timeout", 0, 1, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        din      = '0;
        #3;
        check("rst_ready_in", int'(ready_in), 1, 0);
        check("rst_valid_out", int'(valid_out), 0, 0);
        check("rst_dout", int'(dout), 0, 0);
        check("rst_underrun", int'(underrun), 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Zero input: latency, then 50% density.
        din      = '0;
        valid_in = 1'b1;
        @(negedge clk);
        check("idle_ready_in", int'(ready_in), 1, 0);
        check("idle_valid_out", int'(valid_out), 0, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("first_valid_latency", int'(valid_out), 1, 0);
        check("run_ready_low", int'(ready_in), 0, 0);
        repeat (3) feed(0);

        // FS/2 negative: 25% density.
        repeat (4) feed(-16384);

        // Back-to-back changes, no gap.
        repeat (2) feed(16384);
        repeat (2) feed(-16384);
        check("no_gap_b2b", gaps, 0, 0);

        // Source stops: repeated sample and periodic underrun.
        feed(8192);
        valid_in = 1'b0;
        repeat (OSR * 4 + 32) @(posedge clk);
        #1;
        check("underrun_count", got_ur, exp_ur, 0);
        check("underrun_seen", got_ur, 4, 0);
        check("no_gap_underrun", gaps, 0, 0);

        // Full-scale positive input for over 1000 cycles.
        rst_n = 1'b0;
        #2;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (18) feed(32767);

        // Reset in mid-sample at cnt == 30.
        rst_n = 1'b0;
        #2;
        @(posedge clk);
        #1 rst_n = 1'b1;
        feed(0);
        repeat (33) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid_out", int'(valid_out), 0, 0);
        check("midrst_dout", int'(dout), 0, 0);
        check("midrst_ready_in", int'(ready_in), 1, 0);
        check("midrst_underrun", int'(underrun), 0, 0);
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        feed(0);
        valid_in = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_in && n < 200);
        check("restart_period", n, OSR, 0);
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdm_modulator.md
Name: sdm_modulator

Overview:
- Converts a stream of 16-bit signed PCM samples into a 1-bit sigma-delta bitstream at the bit clock (2.8224 MHz, DSD64 rate).
- It is the transmit-side counterpart of sdm_demodulator. A PCM source feeds it through a valid/ready handshake.
- Each accepted sample is held for OSR bit-clock cycles while the noise-shaping loop emits one bit per cycle.
- Its output can drive sdm_demodulator directly for loopback checking.

Parameters:
DATA_W, 16, PCM sample width (signed two's complement)
OSR, 64, bit-clock cycles per PCM sample; must be >= 2
ACC_W, 24, integrator width (signed); must be >= DATA_W+4

Ports:
clk  input  1  bit clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  PCM sample valid
ready_in  output  1  block can accept a sample this cycle
din  input  DATA_W  signed PCM sample
valid_out  output  1  dout carries a modulator bit
dout  output  1  sigma-delta bitstream (1 = +FS, 0 = -FS)
underrun  output  1  one-cycle pulse: sample period ended with no new sample

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ready_in=1, valid_out=0, dout=0, underrun=0.
  - Integrators, sample register and counter all cleared.
  - Deassertion takes effect on the next clk edge.
- FS = 2^(DATA_W-1). fb = +FS if dout_q=1, else -FS. x = held sample sign-extended to ACC_W.
- State IDLE:
  - ready_in=1, valid_out=0, dout=0.
  - On valid_in & ready_in: latch din, cnt <= OSR-1, go to RUN.
  - Integrators keep their values; they are zero after reset.
- State RUN (one loop step per cycle):
  - i1 <= sat(i1 + x - fb).
  - dout_q <= (i1_next >= 0).
  - valid_out=1.
  - cnt decrements each cycle.
- Latency: first valid_out=1 appears in the cycle after acceptance.
- Saturation: sat() clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; integrators never wrap.
- ready_in=1 in RUN only when cnt==0, the last bit of the current sample.
- At cnt==0:
  - valid_in=1: latch the new sample, cnt <= OSR-1. The bitstream continues with no gap (back-to-back).
  - valid_in=0: reload cnt <= OSR-1 and keep the old sample (repeat). underrun pulses for one cycle. Stay in RUN.
- Once in RUN, the block stays in RUN until reset.
- valid_in while ready_in=0 is ignored; din is not sampled.
- Density: the long-run fraction of ones is (x+FS)/(2·FS).
  - x=0 gives 50%.
  - x=-FS/2 gives 25%.
  - x=FS-1 gives ~100%.
- Reset mid-RUN: outputs return to reset values immediately. A partially emitted sample is discarded.

Optional Feature:
- Macro: SDM_ORDER2_EN.
- Defined: second-order CIFB loop.
  - i1 <= sat(i1 + x - fb).
  - i2 <= sat(i2 + i1_next - fb).
  - dout_q <= (i2_next >= 0).
  - For stability, the latched sample is clamped to ±(3·FS/4) before use.
  - Latency unchanged.
- Undefined: first-order loop only. No i2 register; no input clamp.
- Handshake, counter and underrun behaviour are identical in both builds.

Test Plan:
- Reset, then one sample din=0 with valid_in held:
  - ready_in high in IDLE.
  - First valid_out=1 one cycle after acceptance.
  - After a 2-sample settle, ones count per 64-bit window = 32±1.
- Continuous din=-16384 (FS/2 negative) -> ones per 64-bit window = 16±1. Feeding dout to sdm_demodulator gives a 25% duty-equivalent output.
- Back-to-back samples 16384 then -16384 with valid_in always 1:
  - ready_in high exactly once per 64 cycles.
  - No valid_out gap.
  - Window counts 48±1 then 16±1.
- Source stops after one sample:
  - underrun pulses for 1 cycle every 64 cycles.
  - The bitstream keeps repeating the last sample's density.
- din=32767 for 1000 cycles -> i1 never wraps (check it stays within the ACC_W range); ones per window >= 63. With SDM_ORDER2_EN, the input is clamped and ones per window = 56±2.
- Assert rst_n=0 mid-sample (cnt=30):
  - valid_out=0, dout=0, ready_in=1 in the same cycle.
  - After release, a fresh sample restarts with a full 64-cycle period.
